// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Registered immediate generator with a 2-entry skid buffer.
//            Produces the immediate, pc + imm and an illegal-type flag.
//            Optional macro IMM_GEN_ZICSR_EN enables the Z (zimm) type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter int AUTO_TYPE = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [2:0]      type_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] target_o,
    output logic            illegal_o
);

    localparam logic [2:0] c_TYPE_R   = 3'd0;
    localparam logic [2:0] c_TYPE_I   = 3'd1;
    localparam logic [2:0] c_TYPE_S   = 3'd2;
    localparam logic [2:0] c_TYPE_B   = 3'd3;
    localparam logic [2:0] c_TYPE_U   = 3'd4;
    localparam logic [2:0] c_TYPE_J   = 3'd5;
`ifdef IMM_GEN_ZICSR_EN
    localparam logic [2:0] c_TYPE_Z   = 3'd6;
`endif
    localparam logic [2:0] c_TYPE_BAD = 3'd7;

    logic [2:0]      w_auto_type;
    logic [2:0]      w_type;
    logic [31:0]     w_imm32;
    logic            w_off_zero;
    logic            w_ill;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_off;
    logic [XLEN-1:0] w_tgt;
    logic            w_acc;
    logic            w_drain;
    logic            w_out_load;
    logic            w_skd_next;

    logic            r_in_ready;
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_imm;
    logic [XLEN-1:0] r_out_tgt;
    logic            r_out_ill;
    logic            r_skd_valid;
    logic [XLEN-1:0] r_skd_imm;
    logic [XLEN-1:0] r_skd_tgt;
    logic            r_skd_ill;

    always_comb begin
        w_auto_type = c_TYPE_BAD;
        case (instr_i[6:0])
            7'b0110011:                                w_auto_type = c_TYPE_R;
            7'b0010011, 7'b0000011, 7'b1100111:        w_auto_type = c_TYPE_I;
`ifdef IMM_GEN_ZICSR_EN
            7'b1110011: w_auto_type = instr_i[14] ? c_TYPE_Z : c_TYPE_I;
`else
            7'b1110011:                                w_auto_type = c_TYPE_I;
`endif
            7'b0100011:                                w_auto_type = c_TYPE_S;
            7'b1100011:                                w_auto_type = c_TYPE_B;
            7'b0110111, 7'b0010111:                    w_auto_type = c_TYPE_U;
            7'b1101111:                                w_auto_type = c_TYPE_J;
            default:                                   w_auto_type = c_TYPE_BAD;
        endcase
    end

    assign w_type = (AUTO_TYPE != 0) ? w_auto_type : type_i;

    // Z carries a zimm operand, so it must not offset the target.
    always_comb begin
        w_imm32    = 32'd0;
        w_off_zero = 1'b0;
        w_ill      = 1'b0;
        case (w_type)
            c_TYPE_R: w_imm32 = 32'd0;
            c_TYPE_I: w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            c_TYPE_S: w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            c_TYPE_B: w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                 instr_i[30:25], instr_i[11:8], 1'b0};
            c_TYPE_U: w_imm32 = {instr_i[31:12], 12'd0};
            c_TYPE_J: w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                 instr_i[20], instr_i[30:21], 1'b0};
`ifdef IMM_GEN_ZICSR_EN
            c_TYPE_Z: begin
                w_imm32    = {27'd0, instr_i[19:15]};
                w_off_zero = 1'b1;
            end
`endif
            default:  w_ill = 1'b1;
        endcase
    end

    assign w_imm = XLEN'($signed(w_imm32));
    assign w_off = w_off_zero ? '0 : w_imm;
    assign w_tgt = pc_i + w_off;

    assign w_acc      = in_valid_i & r_in_ready;
    assign w_drain    = r_out_valid & out_ready_i;
    assign w_out_load = !r_out_valid || w_drain;
    assign w_skd_next = w_out_load ? 1'b0 : (r_skd_valid | w_acc);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_imm   <= '0;
            r_out_tgt   <= '0;
            r_out_ill   <= 1'b0;
            r_skd_valid <= 1'b0;
            r_skd_imm   <= '0;
            r_skd_tgt   <= '0;
            r_skd_ill   <= 1'b0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
            r_skd_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_in_ready  <= !w_skd_next;
            r_skd_valid <= w_skd_next;
            if (w_out_load) begin
                // The skid entry is older than any incoming beat.
                r_out_valid <= r_skd_valid | w_acc;
                if (r_skd_valid) begin
                    r_out_imm <= r_skd_imm;
                    r_out_tgt <= r_skd_tgt;
                    r_out_ill <= r_skd_ill;
                end else if (w_acc) begin
                    r_out_imm <= w_imm;
                    r_out_tgt <= w_tgt;
                    r_out_ill <= w_ill;
                end
            end else if (w_acc) begin
                r_skd_imm <= w_imm;
                r_skd_tgt <= w_tgt;
                r_skd_ill <= w_ill;
            end
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign imm_o       = r_out_imm;
    assign target_o    = r_out_tgt;
    assign illegal_o   = r_out_ill;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// Module   : tb_imm_gen_pipe
// Purpose  : Directed self-checking bench for imm_gen_pipe (XLEN=32 manual
//            type, XLEN=64 auto-decoded type).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;

    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [31:0] a_instr = '0;
    logic [2:0]  a_type = '0;
    logic [31:0] a_pc = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b0;
    logic [31:0] a_imm;
    logic [31:0] a_tgt;
    logic        a_ill;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [31:0] b_instr = '0;
    logic [2:0]  b_type = 3'd7;
    logic [63:0] b_pc = '0;
    logic        b_out_valid;
    logic [63:0] b_imm;
    logic [63:0] b_tgt;
    logic        b_ill;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .AUTO_TYPE(0)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .instr_i(a_instr), .type_i(a_type), .pc_i(a_pc), .flush_i(flush),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .imm_o(a_imm), .target_o(a_tgt), .illegal_o(a_ill)
    );

    imm_gen_pipe #(.XLEN(64), .AUTO_TYPE(1)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .instr_i(b_instr), .type_i(b_type), .pc_i(b_pc), .flush_i(1'b0),
        .out_valid_o(b_out_valid), .out_ready_i(1'b1),
        .imm_o(b_imm), .target_o(b_tgt), .illegal_o(b_ill)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat32(input string tag, input logic [31:0] instr, input logic [2:0] typ,
                          input logic [31:0] pc, input logic [31:0] e_imm,
                          input logic [31:0] e_tgt, input logic e_ill);
        a_out_ready = 1'b1;
        a_instr = instr; a_type = typ; a_pc = pc; a_in_valid = 1'b1;
        check({tag, "_rdy"}, 64'(a_in_ready), 64'd1);
        step();
        a_in_valid = 1'b0;
        check({tag, "_vld"}, 64'(a_out_valid), 64'd1);
        check({tag, "_imm"}, 64'(a_imm), 64'(e_imm));
        check({tag, "_tgt"}, 64'(a_tgt), 64'(e_tgt));
        check({tag, "_ill"}, 64'(a_ill), 64'(e_ill));
        step();
    endtask

    task automatic beat64(input string tag, input logic [31:0] instr, input logic [63:0] pc,
                          input logic [63:0] e_imm, input logic [63:0] e_tgt, input logic e_ill);
        b_instr = instr; b_pc = pc; b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        check({tag, "_vld"}, 64'(b_out_valid), 64'd1);
        check({tag, "_imm"}, b_imm, e_imm);
        check({tag, "_tgt"}, b_tgt, e_tgt);
        check({tag, "_ill"}, 64'(b_ill), 64'(e_ill));
        step();
    endtask

    // I-type with immediate n, used to tag beats in the ordering tests
    function automatic logic [31:0] itag(input int n);
        return {12'(n), 20'h00093};
    endfunction

    initial begin
        logic [31:0] got [0:7];
        int          idx;
        logic        acc;

        step(); step();
        check("rst_vld", 64'(a_out_valid), 64'd0);
        check("rst_imm", 64'(a_imm), 64'd0);
        check("rst_tgt", 64'(a_tgt), 64'd0);
        check("rst_ill", 64'(a_ill), 64'd0);
        rst_n = 1'b1;
        step();
        check("rst_rdy", 64'(a_in_ready), 64'd1);

        beat32("btype", 32'hFE000EE3, 3'd3, 32'h00000100, 32'hFFFFFFFC, 32'h000000FC, 1'b0);
        check("drained", 64'(a_out_valid), 64'd0);
        beat32("itype", 32'hFFF00093, 3'd1, 32'h00001000, 32'hFFFFFFFF, 32'h00000FFF, 1'b0);
        beat32("stype", 32'h00112623, 3'd2, 32'h00000200, 32'h0000000C, 32'h0000020C, 1'b0);
        beat32("jwrap", 32'h0080006F, 3'd5, 32'hFFFFFFFC, 32'h00000008, 32'h00000004, 1'b0);
        beat32("utype", 32'h800002B7, 3'd4, 32'h00000010, 32'h80000000, 32'h80000010, 1'b0);
        beat32("rtype", 32'hFFFFFFB3, 3'd0, 32'h00000300, 32'h00000000, 32'h00000300, 1'b0);
        beat32("illeg", 32'hFFF00093, 3'd7, 32'h00000040, 32'h00000000, 32'h00000040, 1'b1);
`ifdef IMM_GEN_ZICSR_EN
        beat32("ztype", 32'h0000D073, 3'd6, 32'h00000050, 32'h00000001, 32'h00000050, 1'b0);
`else
        beat32("ztype", 32'h0000D073, 3'd6, 32'h00000050, 32'h00000000, 32'h00000050, 1'b1);
`endif

        // Backpressure: three beats offered, only two fit
        a_out_ready = 1'b0; a_type = 3'd1; a_pc = 32'h0;
        a_instr = itag(1); a_in_valid = 1'b1; step();
        a_instr = itag(2); step();
        a_instr = itag(3); step();
        check("bp_rdy", 64'(a_in_ready), 64'd0);
        check("bp_head", 64'(a_imm), 64'd1);
        step();
        check("bp_hold", 64'(a_imm), 64'd1);
        a_out_ready = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (a_out_valid && idx < 8) begin
                got[idx] = a_imm;
                idx++;
            end
            acc = a_in_valid & a_in_ready;
            step();
            if (acc) a_in_valid = 1'b0;
        end
        check("bp_count", 64'(idx), 64'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("bp_order%0d", i), 64'(got[i]), 64'(i + 1));
        check("bp_idle_in", 64'(a_in_valid), 64'd0);

        // Flush with OUT and SKD full and a beat on the input
        a_out_ready = 1'b0;
        a_instr = itag(4); a_in_valid = 1'b1; step();
        a_instr = itag(5); step();
        a_instr = itag(6); flush = 1'b1; step();
        flush = 1'b0; a_in_valid = 1'b0;
        check("fl_vld", 64'(a_out_valid), 64'd0);
        check("fl_rdy", 64'(a_in_ready), 64'd1);
        a_out_ready = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (a_out_valid) idx++;
            step();
        end
        check("fl_none", 64'(idx), 64'd0);
        beat32("postfl", 32'h00A00093, 3'd1, 32'h00000020, 32'h0000000A, 32'h0000002A, 1'b0);

        // XLEN=64 with auto-decoded type
        beat64("u64", 32'h800002B7, 64'h1000, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80001000, 1'b0);
        beat64("ill64", 32'h0000000F, 64'h40, 64'h0, 64'h40, 1'b1);
        beat64("b64", 32'hFE000EE3, 64'h100, 64'hFFFFFFFFFFFFFFFC, 64'hFC, 1'b0);
`ifdef IMM_GEN_ZICSR_EN
        beat64("z64", 32'h0000D073, 64'h80, 64'h1, 64'h80, 1'b0);
`else
        beat64("z64", 32'h0000D073, 64'h80, 64'h0, 64'h80, 1'b0);
`endif

        // Asynchronous reset with two beats held
        a_out_ready = 1'b0; a_type = 3'd1;
        a_instr = itag(7); a_in_valid = 1'b1; step();
        a_instr = itag(8); step();
        a_in_valid = 1'b0;
        check("pre_rst_vld", 64'(a_out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 64'(a_out_valid), 64'd0);
        check("mid_rst_imm", 64'(a_imm), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        step();
        check("post_rst_rdy", 64'(a_in_ready), 64'd1);
        check("post_rst_vld", 64'(a_out_valid), 64'd0);
        a_out_ready = 1'b1;
        step();
        check("post_rst_empty", 64'(a_out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
